// File: rtl/mdu_iter_if.sv
// -----------------------------------------------------------------------------
// mdu_iter_if
// Issue/result bundle between the execute stage and the iterative
// multiply/divide unit.
//
// Signals:
//   start  : issue request, sampled only while the unit is idle
//   op     : 00 mult, 01 multu, 10 div, 11 divu
//   a, b   : rs / rt operands, sampled with start
//   hi_we  : mthi strobe (idle only)
//   lo_we  : mtlo strobe (idle only)
//   wdata  : data for mthi/mtlo
//   busy   : operation in flight
//   done   : one-cycle pulse, result committed to hi/lo
//   hi, lo : architectural HI/LO registers
//
// Modports: master drives the request side (execute stage / testbench),
//           slave is the unit itself.
// -----------------------------------------------------------------------------
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter
// Iterative multiply/divide unit for the MIPS execute stage. Runs mult,
// multu, div and divu one radix-2 step per clock and owns the HI/LO
// registers (also written by mthi/mtlo while idle).
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mdu_iter_if.slave (start/op/a/b, hi_we/lo_we/wdata,
//           busy/done, hi/lo)
//
// Parameters:
//   WIDTH : operand and HI/LO width (even, >= 4)
//   CNT_W : step counter width, 2**CNT_W > WIDTH
//
// Build option:
//   MDU_FAST_MUL_EN : when defined, mult/multu use the native multiplier
//                     and complete one edge after issue; divides are
//                     unchanged. HI/LO results are identical either way.
//
// Timing (iterative path): issue at edge E0, WIDTH steps on E1..E_WIDTH,
// result and done after E_WIDTH+1.
// -----------------------------------------------------------------------------
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  mdu_iter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_op;
  logic [CNT_W-1:0]     r_cnt;
  // Multiply: {partial product high, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits / quotient bits}.
  logic [2*WIDTH-1:0]   r_acc;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]     r_opd;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_b_zero;
  logic [WIDTH-1:0]     r_a_orig;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_signed;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_mul_sum;
  logic [WIDTH:0]       w_div_diff;
  logic [2*WIDTH-1:0]   w_step;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;
  logic [WIDTH-1:0]     w_res_hi;
  logic [WIDTH-1:0]     w_res_lo;

  // Operand magnitudes and sign flags for the issue edge; op[0]=0 is signed.
  always_comb begin
    w_signed = ~bus.op[0];
    w_a_neg  = w_signed & bus.a[WIDTH-1];
    w_b_neg  = w_signed & bus.b[WIDTH-1];
    if (w_a_neg) begin
      w_a_mag = ~bus.a + ONE_W;
    end else begin
      w_a_mag = bus.a;
    end
    if (w_b_neg) begin
      w_b_mag = ~bus.b + ONE_W;
    end else begin
      w_b_mag = bus.b;
    end
  end

  // One radix-2 step: shift-add multiply or restoring shift-subtract divide.
  always_comb begin
    // The extra top bit keeps the carry of the high half during the add.
    if (r_acc[0]) begin
      w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opd};
    end else begin
      w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    end
    // Trial subtract on the left-shifted remainder; borrow means restore.
    w_div_diff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opd};
    if (r_op[1]) begin
      if (w_div_diff[WIDTH]) begin
        w_step = {r_acc[2*WIDTH-2:0], 1'b0};
      end else begin
        w_step = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      w_step = {w_mul_sum, r_acc[WIDTH-1:1]};
    end
  end

  // Sign correction and divide-by-zero override applied in FIX.
  always_comb begin
`ifdef MDU_FAST_MUL_EN
    w_prod = {{WIDTH{1'b0}}, r_opd} * {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]};
`else
    w_prod = r_acc;
`endif
    if (r_neg_q) begin
      w_prod_fix = ~w_prod + {{(2*WIDTH-1){1'b0}}, 1'b1};
      w_quo_fix  = ~r_acc[WIDTH-1:0] + ONE_W;
    end else begin
      w_prod_fix = w_prod;
      w_quo_fix  = r_acc[WIDTH-1:0];
    end
    if (r_neg_r) begin
      w_rem_fix = ~r_acc[2*WIDTH-1:WIDTH] + ONE_W;
    end else begin
      w_rem_fix = r_acc[2*WIDTH-1:WIDTH];
    end
    if (!r_op[1]) begin
      w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod_fix[WIDTH-1:0];
    end else if (r_b_zero) begin
      w_res_hi = r_a_orig;
      w_res_lo = {WIDTH{1'b1}};
    end else begin
      w_res_hi = w_rem_fix;
      w_res_lo = w_quo_fix;
    end
  end

  // Next-state logic of the IDLE/RUN/FIX controller.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
`ifdef MDU_FAST_MUL_EN
          if (!bus.op[1]) begin
            w_next = ST_FIX;
          end else begin
            w_next = ST_RUN;
          end
`else
          w_next = ST_RUN;
`endif
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt == LAST_STEP) begin
          w_next = ST_FIX;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_FIX:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath, HI/LO and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op     <= 2'b00;
      r_cnt    <= {CNT_W{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_opd    <= {WIDTH{1'b0}};
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_a_orig <= {WIDTH{1'b0}};
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.hi_we) begin
            r_hi <= bus.wdata;
          end
          if (bus.lo_we) begin
            r_lo <= bus.wdata;
          end
          if (bus.start) begin
            r_op     <= bus.op;
            r_cnt    <= {CNT_W{1'b0}};
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_b_zero <= (bus.b == {WIDTH{1'b0}});
            r_a_orig <= bus.a;
            // High half cleared; low half holds the bits consumed by the steps.
            if (bus.op[1]) begin
              r_opd <= w_b_mag;
              r_acc <= {{WIDTH{1'b0}}, w_a_mag};
            end else begin
              r_opd <= w_a_mag;
              r_acc <= {{WIDTH{1'b0}}, w_b_mag};
            end
          end
        end
        ST_RUN: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        ST_FIX: begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
      r_busy <= (w_next != ST_IDLE);
      r_done <= (r_state == ST_FIX);
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// -----------------------------------------------------------------------------
// tb_mdu_iter
// Directed self-checking bench for mdu_iter. Inputs change and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
// Honours MDU_FAST_MUL_EN for the expected multiply latency.
// -----------------------------------------------------------------------------
module tb_mdu_iter;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  localparam int         DIV_LAT  = 33;
`ifdef MDU_FAST_MUL_EN
  localparam int         MUL_LAT  = 1;
`else
  localparam int         MUL_LAT  = 33;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   lat;
  int   pre;
  logic busy_ok;
  logic seen_done;

  mdu_iter_if #(.WIDTH(32)) bus ();

  mdu_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one issue cycle; returns on the falling edge after E0.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Count edges until done, with a cycle budget; also tracks busy staying high.
  task automatic wait_done(output int e);
    e       = 0;
    busy_ok = 1'b1;
    while (!bus.done && e < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      e++;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                       input int elat);
    int e;
    start_op(o, x, y);
    wait_done(e);
    check({tag, " latency"}, 32'(e), 32'(elat));
    check({tag, " hi"}, bus.hi, ehi);
    check({tag, " lo"}, bus.lo, elo);
    check({tag, " busy held"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " busy at done"}, {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check({tag, " done pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
    do_op("mult -7x3", OP_MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
    do_op("mult -5x-6", OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_001E, MUL_LAT);
    do_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
    do_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);
    do_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT);
    do_op("divu by 0", OP_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, DIV_LAT);
    do_op("div -8 by 0", OP_DIV, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, DIV_LAT);
    do_op("divu 7/100", OP_DIVU, 32'd7, 32'd100, 32'd7, 32'd0, DIV_LAT);

    // mthi alone, then both strobes together.
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_0005;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("mthi hi", bus.hi, 32'h0000_0005);
    check("mthi lo kept", bus.lo, 32'd0);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0BAD_F00D;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("mthi+mtlo hi", bus.hi, 32'h0BAD_F00D);
    check("mthi+mtlo lo", bus.lo, 32'h0BAD_F00D);

    // start and mthi pulsed mid-divide are dropped; hi/lo frozen during RUN.
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    bus.op    = OP_MULT;
    bus.a     = 32'd2;
    bus.b     = 32'd2;
    bus.start = 1'b1;
    bus.hi_we = 1'b1;
    bus.wdata = 32'hAAAA_5555;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    check("busy ign hi", bus.hi, 32'h0BAD_F00D);
    check("busy ign lo", bus.lo, 32'h0BAD_F00D);
    check("busy ign busy", {31'd0, bus.busy}, 32'd1);
    wait_done(lat);
    check("busy ign latency", 32'(lat + 11), 32'(DIV_LAT));
    check("busy ign res hi", bus.hi, 32'd2);
    check("busy ign res lo", bus.lo, 32'd14);
    @(negedge clk);
    check("busy ign no requeue", {31'd0, bus.busy}, 32'd0);

    // start with mtlo in IDLE: write lands at E0, result later overwrites.
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_0077;
    start_op(OP_DIVU, 32'd50, 32'd8);
    bus.lo_we = 1'b0;
    check("start+mtlo lo", bus.lo, 32'h0000_0077);
    wait_done(lat);
    check("start+mtlo res hi", bus.hi, 32'd2);
    check("start+mtlo res lo", bus.lo, 32'd6);
    // Back-to-back issue in the done cycle.
    start_op(OP_MULTU, 32'd5, 32'd6);
    check("b2b busy", {31'd0, bus.busy}, 32'd1);
    wait_done(lat);
    check("b2b latency", 32'(lat), 32'(MUL_LAT));
    check("b2b hi", bus.hi, 32'd0);
    check("b2b lo", bus.lo, 32'd30);
    @(negedge clk);

    // Reset mid-operation aborts with no result and no done pulse.
    start_op(OP_MULT, 32'd3, 32'd4);
    pre = 0;
    repeat (14) begin
      @(negedge clk);
      pre++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("rst mid busy", {31'd0, bus.busy}, 32'd0);
    check("rst mid done", {31'd0, bus.done}, 32'd0);
    check("rst mid hi", bus.hi, 32'd0);
    check("rst mid lo", bus.lo, 32'd0);
    rst_n     = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    check("rst no done", {31'd0, seen_done}, 32'd0);
    do_op("post rst mult", OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, MUL_LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the pipelined MIPS execute stage.
- Handles mult, multu, div and divu, which the single-cycle ALU does not implement.
- Holds the architectural HI/LO registers; they are also written directly by mthi/mtlo.
- Issue uses a start/busy/done handshake so the hazard unit can stall mfhi/mflo until the result is ready.

Parameters:
- WIDTH, 32, operand width and HI/LO width. Must be even and ≥4.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  issue request; sampled only in IDLE
- op  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start
- a  in  WIDTH  rs operand (multiplicand / dividend); sampled with start
- b  in  WIDTH  rt operand (multiplier / divisor); sampled with start
- hi_we  in  1  mthi write strobe
- lo_we  in  1  mtlo write strobe
- wdata  in  WIDTH  data for mthi/mtlo
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse: result committed to hi/lo
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Clock and reset:
  - Single clock; reset synchronous active-low on clk.
  - Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, counter 0.
  - Reset asserted mid-operation aborts it: no hi/lo update, no done pulse.
- FSM states: IDLE, RUN, FIX.
  - IDLE + start (edge E0): latch op, operand magnitudes (signed ops take absolute value) and sign flags. Clear the 2*WIDTH accumulator. counter=0. Go to RUN; busy=1 from after E0.
  - RUN: one radix-2 step per edge. Multiply is shift-add on the multiplier LSB. Divide is restoring shift-subtract, one quotient bit per step. Counter increments each step. After WIDTH steps (edge E_WIDTH), go to FIX.
  - FIX (edge E_WIDTH+1): apply sign correction and special cases, write hi/lo, pulse done=1 for exactly one cycle, busy=0. Go to IDLE.
  - Latency: result and done visible after edge WIDTH+1 (33 for WIDTH=32). Back-to-back start is allowed in the cycle done is high.
- Results:
  - mult/multu: {hi,lo} = full 2*WIDTH product, signed or unsigned. Negate the product when the operand signs differ (signed op only).
  - div/divu: lo=quotient, hi=remainder. Quotient truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero (b==0, both div and divu): lo=all ones, hi=a (original dividend). Overrides the normal correction.
  - Signed overflow: most-negative / -1 gives lo=most-negative (0x80000000), hi=0. This falls out of the magnitude algorithm and needs no special case.
- start while busy: ignored, no queueing; the hazard unit must not issue it.
- mthi/mtlo:
  - hi_we/lo_we in IDLE write wdata to hi/lo on that edge; both strobes may be set at once.
  - Strobes while busy (RUN/FIX) are dropped.
  - start together with hi_we/lo_we in IDLE: the write takes effect at E0, and the operation's result later overwrites both registers.
- hi/lo are held stable throughout RUN. They change only at FIX, on an mthi/mtlo write, or at reset.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined:
  - mult/multu compute the full product combinationally with the native multiplier and go IDLE→FIX directly.
  - Result and done appear after E1; busy is high only between E0 and E1.
  - div/divu are unchanged.
- Undefined: all ops use the iterative path, latency WIDTH+1.
- The hi/lo results are identical in both builds.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF → done after 33 edges, hi=0xFFFFFFFE, lo=0x00000001; busy high for cycles 1..33.
- mult a=-7 (0xFFFFFFF9) b=3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; the same op with the macro defined gives the same values after 1 edge.
- div a=-7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=100 b=7 → lo=14, hi=2.
- Special divides:
  - div a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0.
  - divu a=0x1234 b=0 → lo=0xFFFFFFFF, hi=0x1234.
- Ignored inputs while busy:
  - Start a divu; pulse start and hi_we (wdata=0xAAAA5555) at cycle 10 → both ignored; hi/lo unchanged until FIX, then the divu result appears.
  - In IDLE, hi_we=1, wdata=0x5 → hi=5 next cycle.
- Reset mid-op:
  - Start mult 3×4; deassert rst_n at cycle 15 → busy=0, done never pulses, hi=lo=0.
  - A new start after reset releases completes normally (lo=12).
